uart_rx_stream: RTL

Receive-side glue stage between the serial pin, `UartRxEn` and the RX `socetlib_fifo` in the AHB UART. It synchronizes the raw RX line for the receiver, converts the receiver's `done`/`err` pulses into single FIFO writes with a one-entry hold buffer, and keeps overrun and framing-error statistics. It also raises an idle-timeout flag for partially filled FIFOs and optionally detects line breaks.

---
 rtl/uart_rx_stream.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_stream.sv
// uart_rx_stream: receive-side glue between the RX pin, UartRxEn and the RX FIFO.
// Synchronizes the line and turns done/err pulses into single FIFO writes
// through a one-entry hold buffer. It also keeps saturating overrun and
// framing-error counts and raises an idle-timeout flag.
// Optional break detection: define UART_RX_BREAK_DETECT_EN.
module uart_rx_stream #(
    parameter int unsigned TIMEOUT_TICKS = 512,
    parameter int unsigned BREAK_TICKS   = 176,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             clear,
    input  logic             rx_tick,
    input  logic             rx_in,
    output logic             rx_sync,
    input  logic             rx_done,
    input  logic             rx_err,
    input  logic [7:0]       rx_data,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    output logic             fifo_wen,
    output logic [7:0]       fifo_wdata,
    output logic [ERR_W-1:0] overrun_cnt,
    output logic [ERR_W-1:0] frame_err_cnt,
    output logic             timeout_flag,
    input  logic             timeout_ack,
    output logic             break_flag
);

    localparam int unsigned IW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_TICKS);

    logic             sync1, sync2;
    logic             done_q, err_q;
    logic             cap_pend;
    logic             hold_valid;
    logic [7:0]       hold_data;
    logic [IW-1:0]    idle_cnt;
    logic             done_edge, err_edge, load;
    logic             ovr_inc, idle_set;

    // Edge qualification; an error edge suppresses a simultaneous capture
    always_comb begin
        done_edge  = rx_done && !done_q;
        err_edge   = rx_err && !err_q;
        load       = cap_pend;
        fifo_wen   = hold_valid && !fifo_full;
        fifo_wdata = hold_data;
        ovr_inc    = load && hold_valid && !fifo_wen;
        idle_set   = !load && !fifo_empty && rx_tick && (idle_cnt == IDLE_MAX - 1'b1);
    end

    assign rx_sync = sync2;

    // Two-flop line synchronizer, idle-high, untouched by clear
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_in;
            sync2 <= sync1;
        end
    end

    // Pulse history, capture pipeline and hold buffer
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cap_pend   <= 1'b0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (clear) begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cap_pend   <= 1'b0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else begin
            done_q   <= rx_done;
            err_q    <= rx_err;
            cap_pend <= done_edge && !err_edge;
            if (load) begin
                hold_valid <= 1'b1;
                hold_data  <= rx_data;
            end else if (fifo_wen) begin
                hold_valid <= 1'b0;
            end
        end
    end

    // Saturating overrun and framing-error counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            overrun_cnt   <= '0;
            frame_err_cnt <= '0;
        end else if (clear) begin
            overrun_cnt   <= '0;
            frame_err_cnt <= '0;
        end else begin
            if (ovr_inc && overrun_cnt != '1)
                overrun_cnt <= overrun_cnt + 1'b1;
            if (err_edge && frame_err_cnt != '1)
                frame_err_cnt <= frame_err_cnt + 1'b1;
        end
    end

    // Idle timeout: counter parks at its limit so an ack is not re-flagged
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            idle_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else if (clear) begin
            idle_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (load || fifo_empty)
                idle_cnt <= '0;
            else if (rx_tick && idle_cnt != IDLE_MAX)
                idle_cnt <= idle_cnt + 1'b1;
            if (idle_set)
                timeout_flag <= 1'b1;
            else if (timeout_ack)
                timeout_flag <= 1'b0;
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    localparam int unsigned BW = $clog2(BREAK_TICKS + 1);
    localparam logic [BW-1:0] BRK_MAX = BW'(BREAK_TICKS);

    logic [BW-1:0] brk_cnt;
    logic          brk_flag_q;

    assign break_flag = brk_flag_q;

    // Break detector: counts low-sampled ticks, sticky flag until clear
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            brk_cnt    <= '0;
            brk_flag_q <= 1'b0;
        end else if (clear) begin
            brk_cnt    <= '0;
            brk_flag_q <= 1'b0;
        end else if (rx_sync) begin
            brk_cnt <= '0;
        end else if (rx_tick && brk_cnt != BRK_MAX) begin
            brk_cnt <= brk_cnt + 1'b1;
            if (brk_cnt == BRK_MAX - 1'b1)
                brk_flag_q <= 1'b1;
        end
    end
`else
    assign break_flag = 1'b0;
`endif

endmodule
